// File: rtl/axi_crossbar_rresp.sv
// Read-response responder for one crossbar slave port: merges arbitrated R beats with locally generated DECERR bursts.
// Optional feature: define AXI_CROSSBAR_RRESP_DECERR_CNT_EN to add a saturating decerr_count output.
module axi_crossbar_rresp #(
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   s_rc_id,
  input  logic [7:0]            s_rc_len,
  input  logic                  s_rc_valid,
  output logic                  s_rc_ready,
  input  logic [ID_WIDTH-1:0]   in_rid,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  input  logic [1:0]            in_rresp,
  input  logic                  in_rlast,
  input  logic                  in_rvalid,
  output logic                  in_rready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
`ifdef AXI_CROSSBAR_RRESP_DECERR_CNT_EN
  output logic [15:0]           decerr_count,
`endif
  output logic [ID_WIDTH-1:0]   m_cpl_id,
  output logic                  m_cpl_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FWD    = 2'd1,
    DECERR = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic [ID_WIDTH-1:0] err_id, err_id_nxt;

  logic                  free;
  logic                  load;
  logic [ID_WIDTH-1:0]   ld_id;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [1:0]            ld_resp;
  logic                  ld_last;

  // Next-state and load selection: a decode-error command only wins at a burst boundary
  always_comb begin
    free       = !s_axi_rvalid || s_axi_rready;
    state_nxt  = state;
    cnt_nxt    = cnt;
    err_id_nxt = err_id;
    s_rc_ready = 1'b0;
    in_rready  = 1'b0;
    load       = 1'b0;
    ld_id      = in_rid;
    ld_data    = in_rdata;
    ld_resp    = in_rresp;
    ld_last    = in_rlast;
    unique case (state)
      IDLE: begin
        s_rc_ready = free;
        in_rready  = free && !s_rc_valid;
        if (s_rc_valid && free) begin
          err_id_nxt = s_rc_id;
          cnt_nxt    = s_rc_len;
          state_nxt  = DECERR;
        end else if (in_rvalid && free) begin
          load = 1'b1;
          if (!in_rlast) state_nxt = FWD;
        end
      end
      FWD: begin
        in_rready = free;
        if (in_rvalid && free) begin
          load = 1'b1;
          if (in_rlast) state_nxt = IDLE;
        end
      end
      DECERR: begin
        if (free) begin
          load    = 1'b1;
          ld_id   = err_id;
          ld_data = '0;
          ld_resp = 2'b11;
          ld_last = (cnt == 8'd0);
          if (cnt != 8'd0) cnt_nxt = cnt - 8'd1;
          else             state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      err_id <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      err_id <= err_id_nxt;
    end
  end

  // Output register stage (p0): drains when accepted and nothing new is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
      s_axi_rlast  <= 1'b0;
    end else if (load) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rid    <= ld_id;
      s_axi_rdata  <= ld_data;
      s_axi_rresp  <= ld_resp;
      s_axi_rlast  <= ld_last;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // Completion stage: one pulse per last-beat handshake at the slave port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cpl_valid <= 1'b0;
      m_cpl_id    <= '0;
    end else begin
      m_cpl_valid <= s_axi_rvalid && s_axi_rready && s_axi_rlast;
      if (s_axi_rvalid && s_axi_rready && s_axi_rlast) m_cpl_id <= s_axi_rid;
    end
  end

`ifdef AXI_CROSSBAR_RRESP_DECERR_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Remembers whether the beat held in the output register was generated locally
  logic err_beat_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_beat_p0  <= 1'b0;
      decerr_count <= '0;
    end else begin
      if (load) err_beat_p0 <= (state == DECERR);
      if (s_axi_rvalid && s_axi_rready && s_axi_rlast && err_beat_p0)
        decerr_count <= sat_inc(decerr_count);
    end
  end
`endif

endmodule
